// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, ALU codes,
// FSM states, instruction classes and the datapath strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } ctrl_state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_MULDIV, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } instr_class_e;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, pc_enable;
    logic mar_in, mdr_in, mdr_out, rd, ram_enable;
    logic ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out;
    logic high_in, low_in, high_out, low_out;
    logic gra, grb, grc, r_in, r_out, ba_out, r15_enable;
    logic c_out, con_in, in_port_out, out_port_in;
  } ctrl_sig_t;

  // Number of execute states (T3 onward) each class occupies.
  function automatic logic [2:0] exec_cycles(input instr_class_e c);
    case (c)
      C_ALU_R, C_ALU_I, C_LDI:          return 3'd3;
      C_MULDIV, C_BR:                   return 3'd4;
      C_LD, C_ST:                       return 3'd5;
      C_JAL:                            return 3'd2;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: return 3'd1;
      default:                          return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Opcode decoder: instruction class plus the ALU code driven on CONTROL in T4.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int CTLW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output instr_class_e    iclass,
  output logic [CTLW-1:0] alu_op
);

  always_comb begin
    iclass = C_NOP;
    alu_op = '0;
    case (opcode)
      OP_ADD:  begin iclass = C_ALU_R;  alu_op = ALU_ADD;  end
      OP_SUB:  begin iclass = C_ALU_R;  alu_op = ALU_SUB;  end
      OP_AND:  begin iclass = C_ALU_R;  alu_op = ALU_AND;  end
      OP_OR:   begin iclass = C_ALU_R;  alu_op = ALU_OR;   end
      OP_SHR:  begin iclass = C_ALU_R;  alu_op = ALU_SHR;  end
      OP_SHRA: begin iclass = C_ALU_R;  alu_op = ALU_SHRA; end
      OP_SHL:  begin iclass = C_ALU_R;  alu_op = ALU_SHL;  end
      OP_ROR:  begin iclass = C_ALU_R;  alu_op = ALU_ROR;  end
      OP_ROL:  begin iclass = C_ALU_R;  alu_op = ALU_ROL;  end
      OP_ADDI: begin iclass = C_ALU_I;  alu_op = ALU_ADD;  end
      OP_ANDI: begin iclass = C_ALU_I;  alu_op = ALU_AND;  end
      OP_ORI:  begin iclass = C_ALU_I;  alu_op = ALU_OR;   end
      OP_MUL:  begin iclass = C_MULDIV; alu_op = ALU_MUL;  end
      OP_DIV:  begin iclass = C_MULDIV; alu_op = ALU_DIV;  end
      OP_LDI:  begin iclass = C_LDI;    alu_op = ALU_ADD;  end
      OP_LD:   begin iclass = C_LD;     alu_op = ALU_ADD;  end
      OP_ST:   begin iclass = C_ST;     alu_op = ALU_ADD;  end
      OP_BR:   iclass = C_BR;
      OP_JR:   iclass = C_JR;
      OP_JAL:  iclass = C_JAL;
      OP_IN:   iclass = C_IN;
      OP_OUT:  iclass = C_OUT;
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: sequences fetch (T0-T2) and per-class execute
// states, and owns the run/halt status. Strobes decode from state and IR.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int CTLW = 4
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [31:0]     IR,
  input  logic            CON_FF,
  input  logic            Stop,
  output logic            Run,
  output logic            PCout, PCin, IncPC, PC_enable,
  output logic            MARin, MDRin, MDRout, Read, ram_enable,
  output logic            IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout,
  output logic            highin, lowin, highout, lowout,
  output logic            Gra, Grb, Grc, Rin, Rout, BAout, R15_enable,
  output logic            Cout, con_in, inPortOut, outPortIn,
  output logic [CTLW-1:0] CONTROL,
  output logic [3:0]      dbg_state
);

  ctrl_state_e     state_q, state_d;
  instr_class_e    iclass;
  logic [CTLW-1:0] alu_op;
  logic [CTLW-1:0] alu_sel;
  logic [2:0]      step;
  ctrl_sig_t       sig;
  logic            ir_unused;

  assign ir_unused = ^IR[31-OPW:0];

  ctrl_decode #(.OPW(OPW), .CTLW(CTLW)) u_decode (
    .opcode (IR[31 -: OPW]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  // step counts execute states already done; an instruction ends when it
  // reaches the class's execute length (T2 is step 0 so nop ends there).
  always_comb begin
    state_d = state_q;
    step    = 3'd0;
    case (state_q)
      S_T3:    step = 3'd1;
      S_T4:    step = 3'd2;
      S_T5:    step = 3'd3;
      S_T6:    step = 3'd4;
      S_T7:    step = 3'd5;
      default: step = 3'd0;
    endcase
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (state_q == S_T2 && iclass == C_HALT) begin
          state_d = S_HALT;
        end else if (step >= exec_cycles(iclass)) begin
          state_d = Stop ? S_HALT : S_T0;
        end else begin
          case (state_q)
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            default: state_d = S_T7;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    sig     = '0;
    alu_sel = '0;
    case (state_q)
      S_T0: begin sig.pc_out = 1'b1; sig.mar_in = 1'b1; sig.inc_pc = 1'b1; sig.zlow_in = 1'b1; end
      S_T1: begin sig.zlow_out = 1'b1; sig.pc_in = 1'b1; sig.rd = 1'b1; sig.mdr_in = 1'b1; end
      S_T2: begin sig.mdr_out = 1'b1; sig.ir_in = 1'b1; end
      S_T3: begin
        case (iclass)
          C_ALU_R, C_ALU_I: begin sig.grb = 1'b1; sig.r_out = 1'b1; sig.y_in = 1'b1; end
          C_MULDIV: begin sig.gra = 1'b1; sig.r_out = 1'b1; sig.y_in = 1'b1; end
          C_LDI, C_LD, C_ST: begin sig.grb = 1'b1; sig.ba_out = 1'b1; sig.y_in = 1'b1; end
          C_BR:   begin sig.gra = 1'b1; sig.r_out = 1'b1; sig.con_in = 1'b1; end
          C_JR:   begin sig.gra = 1'b1; sig.r_out = 1'b1; sig.pc_in = 1'b1; end
          C_JAL:  begin sig.pc_out = 1'b1; sig.r15_enable = 1'b1; sig.r_in = 1'b1; end
          C_IN:   begin sig.in_port_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1; end
          C_OUT:  begin sig.gra = 1'b1; sig.r_out = 1'b1; sig.out_port_in = 1'b1; end
          C_MFHI: begin sig.high_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1; end
          C_MFLO: begin sig.low_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_ALU_R:  begin sig.grc = 1'b1; sig.r_out = 1'b1; sig.zlow_in = 1'b1; alu_sel = alu_op; end
          C_ALU_I, C_LDI, C_LD, C_ST: begin sig.c_out = 1'b1; sig.zlow_in = 1'b1; alu_sel = alu_op; end
          C_MULDIV: begin
            sig.grb = 1'b1; sig.r_out = 1'b1; sig.zlow_in = 1'b1; sig.zhigh_in = 1'b1;
            alu_sel = alu_op;
          end
          C_BR:  begin sig.pc_out = 1'b1; sig.y_in = 1'b1; end
          C_JAL: begin sig.gra = 1'b1; sig.r_out = 1'b1; sig.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU_R, C_ALU_I, C_LDI: begin sig.zlow_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1; end
          C_MULDIV:   begin sig.zlow_out = 1'b1; sig.low_in = 1'b1; end
          C_LD, C_ST: begin sig.zlow_out = 1'b1; sig.mar_in = 1'b1; end
          C_BR:       begin sig.c_out = 1'b1; sig.zlow_in = 1'b1; alu_sel = ALU_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_MULDIV: begin sig.zhigh_out = 1'b1; sig.high_in = 1'b1; end
          C_LD:     begin sig.rd = 1'b1; sig.mdr_in = 1'b1; end
          C_ST:     begin sig.gra = 1'b1; sig.r_out = 1'b1; sig.mdr_in = 1'b1; end
          C_BR:     begin sig.zlow_out = 1'b1; sig.pc_enable = 1'b1; sig.pc_in = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD:    begin sig.mdr_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1; end
          C_ST:    sig.ram_enable = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run        = (state_q != S_RESET) && (state_q != S_HALT);
  assign dbg_state  = state_q;
  assign CONTROL    = alu_sel;
  assign PCout      = sig.pc_out;
  assign PCin       = sig.pc_in;
  assign IncPC      = sig.inc_pc;
  assign PC_enable  = sig.pc_enable;
  assign MARin      = sig.mar_in;
  assign MDRin      = sig.mdr_in;
  assign MDRout     = sig.mdr_out;
  assign Read       = sig.rd;
  assign ram_enable = sig.ram_enable;
  assign IRin       = sig.ir_in;
  assign Yin        = sig.y_in;
  assign Zlowin     = sig.zlow_in;
  assign Zhighin    = sig.zhigh_in;
  assign Zlowout    = sig.zlow_out;
  assign Zhighout   = sig.zhigh_out;
  assign highin     = sig.high_in;
  assign lowin      = sig.low_in;
  assign highout    = sig.high_out;
  assign lowout     = sig.low_out;
  assign Gra        = sig.gra;
  assign Grb        = sig.grb;
  assign Grc        = sig.grc;
  assign Rin        = sig.r_in;
  assign Rout       = sig.r_out;
  assign BAout      = sig.ba_out;
  assign R15_enable = sig.r15_enable;
  assign Cout       = sig.c_out;
  assign con_in     = sig.con_in;
  assign inPortOut  = sig.in_port_out;
  assign outPortIn  = sig.out_port_in;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences come from a
// table-level reference model and are compared every cycle.
module tb_control_unit;

  localparam int W = 35;
  localparam int P_PCOUT = 0,  P_PCIN = 1,   P_INCPC = 2,  P_PCEN = 3;
  localparam int P_MARIN = 4,  P_MDRIN = 5,  P_MDROUT = 6, P_READ = 7, P_RAMEN = 8;
  localparam int P_IRIN = 9,   P_YIN = 10,   P_ZLIN = 11,  P_ZHIN = 12, P_ZLOUT = 13, P_ZHOUT = 14;
  localparam int P_HIIN = 15,  P_LOIN = 16,  P_HIOUT = 17, P_LOOUT = 18;
  localparam int P_GRA = 19,   P_GRB = 20,   P_GRC = 21,   P_RIN = 22, P_ROUT = 23, P_BAOUT = 24, P_R15 = 25;
  localparam int P_COUT = 26,  P_CONIN = 27, P_INPORT = 28, P_OUTPORT = 29, P_RUN = 30;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7, OP_SHRA = 5'd8, OP_SHL = 5'd9;
  localparam logic [4:0] OP_ROR = 5'd10, OP_ROL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
  localparam logic [4:0] OP_MUL = 5'd15, OP_DIV = 5'd16, OP_BR = 5'd18, OP_JR = 5'd19, OP_JAL = 5'd20;
  localparam logic [4:0] OP_IN = 5'd21, OP_OUT = 5'd22, OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_HALT = 5'd26;

  logic        Clock = 1'b0;
  logic        Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic        Run, PCout, PCin, IncPC, PC_enable, MARin, MDRin, MDRout, Read, ram_enable;
  logic        IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, highin, lowin, highout, lowout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, R15_enable, Cout, con_in, inPortOut, outPortIn;
  logic [3:0]  CONTROL;
  logic [3:0]  dbg_state;
  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .PC_enable(PC_enable),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .ram_enable(ram_enable),
    .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .highin(highin), .lowin(lowin), .highout(highout), .lowout(lowout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .R15_enable(R15_enable),
    .Cout(Cout), .con_in(con_in), .inPortOut(inPortOut), .outPortIn(outPortIn),
    .CONTROL(CONTROL), .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  assign obs = {CONTROL, Run, outPortIn, inPortOut, con_in, Cout, R15_enable, BAout, Rout, Rin,
                Grc, Grb, Gra, lowout, highout, lowin, highin, Zhighout, Zlowout, Zhighin, Zlowin,
                Yin, IRin, ram_enable, Read, MDRout, MDRin, MARin, PC_enable, IncPC, PCin, PCout};

  function automatic logic [W-1:0] m(input int p);
    logic [W-1:0] one = 1;
    return one << p;
  endfunction

  function automatic logic [W-1:0] ctl(input logic [3:0] c);
    logic [W-1:0] r = '0;
    r[W-1 -: 4] = c;
    return r;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_AND, OP_ANDI: return 4'd0;
      OP_OR, OP_ORI:   return 4'd1;
      OP_ADD, OP_ADDI: return 4'd2;
      OP_SUB:  return 4'd3;
      OP_SHR:  return 4'd4;
      OP_SHRA: return 4'd5;
      OP_SHL:  return 4'd6;
      OP_ROR:  return 4'd7;
      OP_ROL:  return 4'd8;
      OP_MUL:  return 4'd9;
      OP_DIV:  return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  // Expected strobe set for every cycle of one instruction, fetch included.
  task automatic model_instr(input logic [4:0] op, input logic con, output bit to_halt);
    logic [W-1:0] r;
    r = m(P_RUN);
    to_halt = 1'b0;
    exp_q.delete();
    exp_q.push_back(r | m(P_PCOUT) | m(P_MARIN) | m(P_INCPC) | m(P_ZLIN));
    exp_q.push_back(r | m(P_ZLOUT) | m(P_PCIN) | m(P_READ) | m(P_MDRIN));
    exp_q.push_back(r | m(P_MDROUT) | m(P_IRIN));
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI: begin
        exp_q.push_back(r | m(P_GRB) | m(P_ROUT) | m(P_YIN));
        if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI)
          exp_q.push_back(r | m(P_COUT) | m(P_ZLIN) | ctl(alu_of(op)));
        else
          exp_q.push_back(r | m(P_GRC) | m(P_ROUT) | m(P_ZLIN) | ctl(alu_of(op)));
        exp_q.push_back(r | m(P_ZLOUT) | m(P_GRA) | m(P_RIN));
      end
      OP_MUL, OP_DIV: begin
        exp_q.push_back(r | m(P_GRA) | m(P_ROUT) | m(P_YIN));
        exp_q.push_back(r | m(P_GRB) | m(P_ROUT) | m(P_ZLIN) | m(P_ZHIN) | ctl(alu_of(op)));
        exp_q.push_back(r | m(P_ZLOUT) | m(P_LOIN));
        exp_q.push_back(r | m(P_ZHOUT) | m(P_HIIN));
      end
      OP_LDI, OP_LD, OP_ST: begin
        exp_q.push_back(r | m(P_GRB) | m(P_BAOUT) | m(P_YIN));
        exp_q.push_back(r | m(P_COUT) | m(P_ZLIN) | ctl(4'd2));
        if (op == OP_LDI) begin
          exp_q.push_back(r | m(P_ZLOUT) | m(P_GRA) | m(P_RIN));
        end else begin
          exp_q.push_back(r | m(P_ZLOUT) | m(P_MARIN));
          if (op == OP_LD) begin
            exp_q.push_back(r | m(P_READ) | m(P_MDRIN));
            exp_q.push_back(r | m(P_MDROUT) | m(P_GRA) | m(P_RIN));
          end else begin
            exp_q.push_back(r | m(P_GRA) | m(P_ROUT) | m(P_MDRIN));
            exp_q.push_back(r | m(P_RAMEN));
          end
        end
      end
      OP_BR: begin
        exp_q.push_back(r | m(P_GRA) | m(P_ROUT) | m(P_CONIN));
        exp_q.push_back(r | m(P_PCOUT) | m(P_YIN));
        exp_q.push_back(r | m(P_COUT) | m(P_ZLIN) | ctl(4'd2));
        exp_q.push_back(r | m(P_ZLOUT) | m(P_PCEN) | (con ? m(P_PCIN) : '0));
      end
      OP_JR:   exp_q.push_back(r | m(P_GRA) | m(P_ROUT) | m(P_PCIN));
      OP_JAL: begin
        exp_q.push_back(r | m(P_PCOUT) | m(P_R15) | m(P_RIN));
        exp_q.push_back(r | m(P_GRA) | m(P_ROUT) | m(P_PCIN));
      end
      OP_IN:   exp_q.push_back(r | m(P_INPORT) | m(P_GRA) | m(P_RIN));
      OP_OUT:  exp_q.push_back(r | m(P_GRA) | m(P_ROUT) | m(P_OUTPORT));
      OP_MFHI: exp_q.push_back(r | m(P_HIOUT) | m(P_GRA) | m(P_RIN));
      OP_MFLO: exp_q.push_back(r | m(P_LOOUT) | m(P_GRA) | m(P_RIN));
      OP_HALT: to_halt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (state=%0d)", tag, got, want, dbg_state);
    end
  endtask

  // Entered #1 after the edge into T0. stop_sel/clear_sel: -1 none, -2 last
  // cycle, -3 random cycle, otherwise a cycle index (0 = T0).
  task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_sel,
                           input int clear_sel, output bit halted);
    bit to_halt;
    int n, stop_at, clear_at;
    model_instr(ir[31:27], con, to_halt);
    n = exp_q.size();
    stop_at  = (stop_sel == -2) ? n - 1 : (stop_sel == -3) ? int'($urandom_range(n - 2, 0)) : stop_sel;
    clear_at = (clear_sel == -3) ? int'($urandom_range(n - 1, 0)) : clear_sel;
    halted = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == 2) begin IR = ir; CON_FF = con; end
      Stop  = (k == stop_at);
      Clear = (k == clear_at);
      #1;
      check($sformatf("op%0d_t%0d", ir[31:27], k), obs, exp_q.pop_front());
      @(posedge Clock); #1;
      if (k == clear_at) begin
        Clear = 1'b0;
        Stop  = 1'b0;
        check("clear_to_reset", obs, '0);
        @(posedge Clock); #1;
        return;
      end
    end
    Stop = 1'b0;
    halted = to_halt || (stop_at == n - 1);
  endtask

  task automatic halt_phase();
    for (int i = 0; i < 3; i++) begin
      IR = $urandom;
      CON_FF = ($urandom_range(1, 0) != 0);
      Stop = ($urandom_range(1, 0) != 0);
      #1;
      check("halt_hold", obs, '0);
      @(posedge Clock); #1;
    end
    Stop = 1'b0;
    Clear = 1'b1;
    #1;
    check("halt_pre_clear", obs, '0);
    @(posedge Clock); #1;
    Clear = 1'b0;
    check("halt_reset", obs, '0);
    @(posedge Clock); #1;
  endtask

  initial begin
    bit h;
    Clear = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = '0;
    @(posedge Clock); #1;
    check("reset_a", obs, '0);
    @(posedge Clock); #1;
    check("reset_b", obs, '0);
    Clear = 1'b0;
    @(posedge Clock); #1;

    run_instr(32'h18918000, 1'b0, -1, -1, h);
    run_instr(32'h91000023, 1'b1, -1, -1, h);
    run_instr(32'h91000023, 1'b0, -1, -1, h);
    run_instr(32'h00900055, 1'b0, -1, -1, h);
    run_instr({OP_ST, 27'h0880010}, 1'b0, -1, 5, h);
    run_instr(32'h18918000, 1'b0, -2, -1, h);
    if (h) halt_phase();
    else begin errors++; $error("FAIL add_stop_halt: observed=no_halt expected=halt"); end

    for (int op = 0; op < 32; op++) begin
      logic [31:0] ir;
      ir = $urandom;
      ir[31:27] = 5'(op);
      run_instr(ir, ($urandom_range(1, 0) != 0), -3, -1, h);
      if (h) halt_phase();
    end

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ir;
      int r, ss, cs;
      ir = $urandom;
      r  = int'($urandom_range(15, 0));
      ss = (r < 2) ? -2 : (r < 6) ? -3 : -1;
      cs = (r == 15) ? -3 : -1;
      run_instr(ir, ($urandom_range(1, 0) != 0), ss, cs, h);
      if (h) halt_phase();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control unit that sequences the single-bus datapath through fetch and execute of every instruction.
- Replaces hand-written per-instruction bench FSMs.
- Sits beside the datapath: takes the IR contents and the CON FF flag, and drives every datapath strobe once per Clock cycle.
- Owns the run/halt status of the CPU.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- CTLW, 4, width of the ALU select bus CONTROL.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents; opcode in IR[31:27].
- CON_FF  in  1  branch-condition flag from the datapath.
- Stop  in  1  external halt request; sampled at instruction end.
- Run  out  1  1 while executing; 0 in RESET and HALT.
- PCout, PCin, IncPC, PC_enable  out  1 each  PC strobes.
- MARin, MDRin, MDRout, Read, ram_enable  out  1 each  memory strobes; ram_enable is the RAM write strobe.
- IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout  out  1 each  IR, Y and Z strobes.
- highin, lowin, highout, lowout  out  1 each  HI/LO register strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, R15_enable  out  1 each  register-file select/strobes.
- Cout, con_in, inPortOut, outPortIn  out  1 each  immediate, condition-logic and port strobes.
- CONTROL  out  CTLW  ALU operation select.

Behaviour:
- Clock and reset: one clock. Clear is synchronous active-high: at the next edge state goes to RESET, regardless of the current state, including mid-instruction.
- Output encoding: outputs are combinational decodes of the state register and IR[31:27]. No glitch-sensitive loads; the datapath samples on the edge.
- RESET state: all outputs 0, CONTROL=0, Run=0. Next state is T0 once Clear is low.
- One state per cycle. Any strobe not listed for a state is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute states T3.. depend on the opcode class decoded from IR:
  - ALU R-type (add, sub, and, or, shl, shr, shra, rol, ror): T3 Grb Rout Yin; T4 Grc Rout Zlowin CONTROL=op; T5 Zlowout Gra Rin.
  - ALU immediate (addi, andi, ori): same as R-type, except T4 uses Cout in place of Grc Rout.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout Zlowin Zhighin CONTROL=op; T5 Zlowout lowin; T6 Zhighout highin.
  - ldi: T3 Grb BAout Yin; T4 Cout Zlowin CONTROL=ADD; T5 Zlowout Gra Rin.
  - ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 ram_enable.
  - br (opcode 5'b10010, all condition variants): T3 Gra Rout con_in; T4 PCout Yin; T5 Cout Zlowin CONTROL=ADD; T6 Zlowout PC_enable, with PCin asserted iff CON_FF=1.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout R15_enable Rin; T4 Gra Rout PCin.
  - in: T3 inPortOut Gra Rin.
  - out: T3 Gra Rout outPortIn.
  - mfhi: T3 highout Gra Rin.
  - mflo: T3 lowout Gra Rin.
  - nop and undefined opcodes: no T3; after T2, go directly to T0.
  - halt: after T2, go to HALT.
- Instruction end: the last state of each sequence goes to T0, or to HALT if Stop=1 in that cycle. A Stop pulse that falls in any other cycle is ignored.
- HALT: all strobes 0, Run=0. Left only by Clear.
- Latency: total cycles per instruction = 3 fetch + execute count.
  - R-type, immediate, ldi: 6
  - mul/div, br: 7
  - ld, st: 8
  - jal: 5
  - jr, in, out, mfhi, mflo: 4
  - nop: 3
- IR stability: IR changes only at the T2 edge. Decode in T3+ uses the newly loaded IR.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants (br = 5'b10010);
  - ALU codes (ALU_ADD = 4'd2, plus the rest);
  - the state enum (RESET, T0–T7, HALT);
  - the instruction-class enum.
- Sub-module ctrl_decode: combinational; maps opcode to instruction class and CONTROL code. The FSM stays in control_unit.

Test Plan:
- Clear=1 for 2 cycles, then 0 -> all outputs 0 and Run=0 during Clear; T0 on the first cycle after Clear, with PCout=MARin=IncPC=Zlowin=1.
- IR=32'h18918000 (add R1,R2,R3) -> exactly 6 cycles; T4 shows Grc Rout Zlowin with CONTROL=ALU_ADD; T5 Zlowout Gra Rin; then T0.
- IR=32'h91000023 with CON_FF=1 -> PCin=1 only in T6 (alongside Zlowout PC_enable). Repeat with CON_FF=0 -> PCin=0 throughout T3–T6.
- IR=32'h00900055 (ld R1,0x55(R2)) -> 8 cycles; Read=1 only in T1 and T6; MDRout Gra Rin in T7.
- Clear asserted in T5 of a st -> ram_enable never pulses; RESET on the next edge, then T0.
- Stop=1 in the final cycle of an add -> HALT with Run=0; IR changes are ignored; only Clear restarts.
